// File: rtl/pwm_pkg.sv
// Constants shared by the PWM generator and the PWM capture block so both
// sides agree on the top/compare encoding.
package pwm_pkg;

    localparam int TOP_W      = 8;
    localparam int CMP_W      = 9;
    localparam int MAX_PERIOD = 256;

    typedef logic [TOP_W-1:0] top_t;
    typedef logic [CMP_W-1:0] cmp_t;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } cap_state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// Result bus of the PWM capture block: recovered top/compare pair, strobes
// and the synchronized input level.
interface pwm_capture_if;
    import pwm_pkg::*;

    top_t o_top;
    logic o_top_valid;
    cmp_t o_compare;
    logic o_compare_valid;
    logic o_overflow;
    logic o_level;

    modport master (
        output o_top, o_top_valid, o_compare, o_compare_valid, o_overflow, o_level
    );

    modport slave (
        input o_top, o_top_valid, o_compare, o_compare_valid, o_overflow, o_level
    );

endinterface

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level into the i_clk domain and flags its
// rising and falling edges.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_s,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // Next state of the synchronizer chain and the previous-level flop.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and previous-level registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_s    = sync_q[SYNC_STAGES-1];
    assign o_rise = o_s & ~prev_q;
    assign o_fall = ~o_s & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures an incoming PWM waveform and reports it as the generator's own
// top (period - 1) / compare (high cycles) pair.
module pwm_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_PERIOD  = pwm_pkg::MAX_PERIOD
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_pwm,
    pwm_capture_if.master cap
);
    import pwm_pkg::*;

    localparam cmp_t MAX_CNT   = CMP_W'(MAX_PERIOD);
    localparam cmp_t STUCK_CNT = CMP_W'(MAX_PERIOD - 1);

    logic       s_s;
    logic       rise_s;
    logic       fall_s;
    logic       edge_s;
    logic       stuck_s;

    cap_state_e state_q,    state_d;
    cmp_t       per_cnt_q,  per_cnt_d;
    cmp_t       hi_cnt_q,   hi_cnt_d;
    cmp_t       idle_cnt_q, idle_cnt_d;
    top_t       top_q,      top_d;
    cmp_t       cmp_q,      cmp_d;
    logic       valid_q,    valid_d;
    logic       ovf_q,      ovf_d;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_pwm),
        .o_s     (s_s),
        .o_rise  (rise_s),
        .o_fall  (fall_s)
    );

    assign edge_s  = rise_s | fall_s;
    assign stuck_s = (idle_cnt_q == STUCK_CNT) && !edge_s;

    // Measurement FSM: a rise closes the running period and opens the next;
    // a static input is reported as 0% / 100% duty and wins over overflow.
    always_comb begin
        state_d    = state_q;
        per_cnt_d  = per_cnt_q;
        hi_cnt_d   = hi_cnt_q;
        idle_cnt_d = edge_s ? 9'd0 : (idle_cnt_q + 9'd1);
        top_d      = top_q;
        cmp_d      = cmp_q;
        valid_d    = 1'b0;
        ovf_d      = 1'b0;
        if (stuck_s) begin
            valid_d    = 1'b1;
            top_d      = 8'hFF;
            cmp_d      = s_s ? MAX_CNT : 9'd0;
            idle_cnt_d = 9'd0;
            state_d    = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise_s) begin
                        per_cnt_d = 9'd1;
                        hi_cnt_d  = 9'd1;
                        state_d   = ST_MEASURE;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
                ST_MEASURE: begin
                    if (rise_s) begin
                        valid_d   = 1'b1;
                        top_d     = top_t'(per_cnt_q - 9'd1);
                        cmp_d     = hi_cnt_q;
                        per_cnt_d = 9'd1;
                        hi_cnt_d  = 9'd1;
                    end else if (per_cnt_q == MAX_CNT) begin
                        ovf_d     = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        per_cnt_d = per_cnt_q + 9'd1;
                        hi_cnt_d  = s_s ? (hi_cnt_q + 9'd1) : hi_cnt_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            per_cnt_q  <= 9'd0;
            hi_cnt_q   <= 9'd0;
            idle_cnt_q <= 9'd0;
            top_q      <= 8'd0;
            cmp_q      <= 9'd0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            hi_cnt_q   <= hi_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            top_q      <= top_d;
            cmp_q      <= cmp_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign cap.o_top           = top_q;
    assign cap.o_compare       = cmp_q;
    assign cap.o_top_valid     = valid_q;
    assign cap.o_compare_valid = valid_q;
    assign cap.o_overflow      = ovf_q;
    assign cap.o_level         = s_s;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed and random waveforms checked
// cycle by cycle against a timestamp-based reference model.
module tb_pwm_capture;

    localparam int SYNC = 2;
    localparam int MAXP = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pwm   = 1'b0;

    pwm_capture_if cap_if ();

    pwm_capture #(
        .SYNC_STAGES (SYNC),
        .MAX_PERIOD  (MAXP)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_pwm   (pwm),
        .cap     (cap_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit wave[$];
    int n_valid, n_ovf, first_valid, last_valid, last_top, last_cmp;

    task automatic add_seg(input bit v, input int len);
        for (int i = 0; i < len; i++) wave.push_back(v);
    endtask

    // Reset, play the waveform in 'wave' one sample per clock and compare every cycle.
    task automatic run_wave();
        bit s_seq[$];
        int ev_kind[$];
        int ev_top[$];
        int ev_cmp[$];
        int n, last_ref, start, hi, exp_top, exp_cmp, c;
        bit meas, s, p;
        for (int i = 0; i < SYNC; i++) s_seq.push_back(1'b0);
        foreach (wave[i]) s_seq.push_back(wave[i]);
        n = s_seq.size();
        // Model: last_ref = cycle of last edge or stuck report, start = cycle of opening rise.
        last_ref = -1; meas = 1'b0; start = 0;
        for (int i = 0; i < n; i++) begin
            s = s_seq[i];
            p = (i == 0) ? 1'b0 : s_seq[i-1];
            if (s == p && i - last_ref == MAXP) begin
                ev_kind.push_back(1); ev_top.push_back(MAXP - 1); ev_cmp.push_back(s ? MAXP : 0);
                meas = 1'b0; last_ref = i;
            end else if (meas && s && !p) begin
                hi = 0;
                for (int j = start; j < i; j++) hi += int'(s_seq[j]);
                ev_kind.push_back(1); ev_top.push_back(i - start - 1); ev_cmp.push_back(hi);
                start = i;
            end else if (meas && i - start == MAXP) begin
                ev_kind.push_back(2); ev_top.push_back(0); ev_cmp.push_back(0);
                meas = 1'b0;
            end else begin
                ev_kind.push_back(0); ev_top.push_back(0); ev_cmp.push_back(0);
                if (!meas && s && !p) begin meas = 1'b1; start = i; end
            end
            if (s != p) last_ref = i;
        end

        n_valid = 0; n_ovf = 0; first_valid = -1; last_valid = -1; last_top = -1; last_cmp = -1;
        exp_top = 0; exp_cmp = 0;
        @(posedge clk); #1; rst_n = 1'b0;
        for (int k = 0; k <= n; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                rst_n = 1'b1;
                checks++;
                if ({cap_if.o_top, cap_if.o_top_valid, cap_if.o_compare, cap_if.o_compare_valid,
                     cap_if.o_overflow, cap_if.o_level} !== 21'd0) begin
                    errors++;
                    $display("FAIL reset_outputs: top=%0d cmp=%0d v=%b cv=%b ovf=%b lvl=%b, want all 0",
                             cap_if.o_top, cap_if.o_compare, cap_if.o_top_valid,
                             cap_if.o_compare_valid, cap_if.o_overflow, cap_if.o_level);
                end
            end else begin
                c = k - 1;
                checks++;
                if (cap_if.o_top_valid !== (ev_kind[c] == 1)) begin
                    errors++;
                    $display("FAIL top_valid @%0d: got %b want %b", c, cap_if.o_top_valid, ev_kind[c] == 1);
                end
                checks++;
                if (cap_if.o_compare_valid !== (ev_kind[c] == 1)) begin
                    errors++;
                    $display("FAIL compare_valid @%0d: got %b want %b", c, cap_if.o_compare_valid, ev_kind[c] == 1);
                end
                checks++;
                if (cap_if.o_overflow !== (ev_kind[c] == 2)) begin
                    errors++;
                    $display("FAIL overflow @%0d: got %b want %b", c, cap_if.o_overflow, ev_kind[c] == 2);
                end
                if (ev_kind[c] == 1) begin
                    exp_top = ev_top[c];
                    exp_cmp = ev_cmp[c];
                end
                checks++;
                if (cap_if.o_top !== 8'(exp_top)) begin
                    errors++;
                    $display("FAIL top @%0d: got %0d want %0d", c, cap_if.o_top, exp_top);
                end
                checks++;
                if (cap_if.o_compare !== 9'(exp_cmp)) begin
                    errors++;
                    $display("FAIL compare @%0d: got %0d want %0d", c, cap_if.o_compare, exp_cmp);
                end
                if (cap_if.o_top_valid === 1'b1) begin
                    n_valid++;
                    if (first_valid < 0) first_valid = k;
                    last_valid = k;
                    last_top   = int'(cap_if.o_top);
                    last_cmp   = int'(cap_if.o_compare);
                end
                if (cap_if.o_overflow === 1'b1) n_ovf++;
            end
            if (k < n) begin
                checks++;
                if (cap_if.o_level !== s_seq[k]) begin
                    errors++;
                    $display("FAIL level @%0d: got %b want %b", k, cap_if.o_level, s_seq[k]);
                end
            end
            pwm = (k < wave.size()) ? wave[k] : wave[wave.size()-1];
        end
        wave.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            pwm = 1'($urandom_range(0, 1));
        end
        checks++;
        if (cap_if.o_top !== 8'd0 || cap_if.o_compare !== 9'd0 || cap_if.o_top_valid !== 1'b0 ||
            cap_if.o_compare_valid !== 1'b0 || cap_if.o_overflow !== 1'b0 || cap_if.o_level !== 1'b0) begin
            errors++;
            $display("FAIL power_on_reset: top=%0d cmp=%0d lvl=%b, want 0", cap_if.o_top, cap_if.o_compare, cap_if.o_level);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_loopback();
        for (int r = 0; r < 5; r++) begin add_seg(1'b1, 25); add_seg(1'b0, 75); end
        run_wave();
        checks++;
        if (n_valid != 4 || last_top != 99 || last_cmp != 25) begin
            errors++;
            $display("FAIL loopback: strobes=%0d top=%0d cmp=%0d, want 4/99/25", n_valid, last_top, last_cmp);
        end
        checks++;
        if (last_valid - first_valid != 300) begin
            errors++;
            $display("FAIL loopback_spacing: got %0d want 300", last_valid - first_valid);
        end
    endtask

    task automatic test_toggle();
        for (int r = 0; r < 20; r++) begin add_seg(1'b1, 1); add_seg(1'b0, 1); end
        run_wave();
        checks++;
        if (n_valid != 19 || last_top != 1 || last_cmp != 1) begin
            errors++;
            $display("FAIL toggle: strobes=%0d top=%0d cmp=%0d, want 19/1/1", n_valid, last_top, last_cmp);
        end
    endtask

    task automatic test_stuck();
        add_seg(1'b1, 600);
        run_wave();
        checks++;
        if (n_valid != 2 || n_ovf != 0 || last_top != 255 || last_cmp != 256) begin
            errors++;
            $display("FAIL stuck_high: strobes=%0d ovf=%0d top=%0d cmp=%0d, want 2/0/255/256", n_valid, n_ovf, last_top, last_cmp);
        end
        add_seg(1'b0, 600);
        run_wave();
        checks++;
        if (n_valid != 2 || n_ovf != 0 || last_top != 255 || last_cmp != 0) begin
            errors++;
            $display("FAIL stuck_low: strobes=%0d ovf=%0d top=%0d cmp=%0d, want 2/0/255/0", n_valid, n_ovf, last_top, last_cmp);
        end
    endtask

    task automatic test_overflow();
        for (int r = 0; r < 2; r++) begin add_seg(1'b1, 10); add_seg(1'b0, 290); end
        for (int r = 0; r < 2; r++) begin add_seg(1'b1, 10); add_seg(1'b0, 10); end
        run_wave();
        checks++;
        if (n_ovf != 2 || n_valid != 3 || last_top != 19 || last_cmp != 10) begin
            errors++;
            $display("FAIL overflow_scenario: ovf=%0d strobes=%0d top=%0d cmp=%0d, want 2/3/19/10", n_ovf, n_valid, last_top, last_cmp);
        end
    endtask

    task automatic test_period_256();
        for (int r = 0; r < 4; r++) begin add_seg(1'b1, 128); add_seg(1'b0, 128); end
        run_wave();
        checks++;
        if (n_valid != 3 || n_ovf != 0 || last_top != 255 || last_cmp != 128) begin
            errors++;
            $display("FAIL period_256: strobes=%0d ovf=%0d top=%0d cmp=%0d, want 3/0/255/128", n_valid, n_ovf, last_top, last_cmp);
        end
    endtask

    task automatic test_mid_reset();
        for (int r = 0; r < 2; r++) begin add_seg(1'b1, 5); add_seg(1'b0, 15); end
        add_seg(1'b1, 5); add_seg(1'b0, 3);
        run_wave();
        for (int r = 0; r < 3; r++) begin add_seg(1'b1, 7); add_seg(1'b0, 13); end
        run_wave();
        checks++;
        if (first_valid != 23 || n_valid != 2 || last_top != 19 || last_cmp != 7) begin
            errors++;
            $display("FAIL mid_reset: first=%0d strobes=%0d top=%0d cmp=%0d, want 23/2/19/7", first_valid, n_valid, last_top, last_cmp);
        end
    endtask

    task automatic test_random();
        int per, hi;
        for (int t = 0; t < 6; t++) begin
            per = $urandom_range(2, 300);
            hi  = $urandom_range(0, per);
            for (int r = 0; r < 3; r++) begin add_seg(1'b1, hi); add_seg(1'b0, per - hi); end
            run_wave();
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_toggle();
        test_stuck();
        test_overflow();
        test_period_256();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
